// File: rtl/lzs_decode_engine.sv
// LZS token decoder with an internal history window and overlapping match-copy engine.
// Define LZS_ERR_CHECK_EN to enable offset/length stream checking; otherwise err is tied low.
module lzs_decode_engine #(
    parameter int unsigned HIST_AW = 11,
    parameter int unsigned LEN_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_decode,
    input  logic        fo_full,
    input  logic [12:0] stream_data,
    input  logic        stream_valid,
    output logic [3:0]  stream_width,
    output logic        stream_ack,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        all_end,
    output logic        err
);
    localparam int unsigned DEPTH = 1 << HIST_AW;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_PROC, S_LEN1, S_LEN2, S_LEN3, S_COPY, S_END
    } state_t;

    state_t             state_q;
    logic [HIST_AW-1:0] waddr_q;
    logic [HIST_AW-1:0] offset_q;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         out_data_q;
    logic               out_valid_q;
    logic               all_end_q;
    logic [7:0]         hist_mem [DEPTH];

    logic               go_c;
    logic               eom_c;
    logic               lit_c;
    logic               long_c;
    logic               copy_rd_c;
    logic               len_sat_c;
    logic [LEN_W:0]     len_sum_c;
    logic [HIST_AW-1:0] offset_d;
    logic [HIST_AW-1:0] waddr_d;
    logic [HIST_AW-1:0] raddr_c;
    logic [7:0]         rd_byte_c;

`ifdef LZS_ERR_CHECK_EN
    localparam int unsigned CNT_W = HIST_AW + 1;
    logic [CNT_W-1:0]   wcount_q;
    logic [CNT_W-1:0]   wcount_d;
    logic               bad_off_c;
    logic               err_q;
`endif

    // Token decode, copy address generation and the aligner consume handshake.
    always_comb begin
        go_c      = stream_valid && !fo_full;
        eom_c     = (stream_data[12:4] == 9'b110000000);
        lit_c     = !stream_data[12];
        long_c    = (stream_data[12:11] == 2'b10);
        offset_d  = long_c ? HIST_AW'(stream_data[10:0]) : HIST_AW'(stream_data[10:4]);
        waddr_d   = waddr_q + HIST_AW'(out_valid_q);
        raddr_c   = waddr_d - offset_q;
        // The byte being written this cycle is not in the array yet; forward it.
        rd_byte_c = (out_valid_q && (raddr_c == waddr_q)) ? out_data_q : hist_mem[raddr_c];
        copy_rd_c = (state_q == S_COPY) && !fo_full;
        len_sum_c = {1'b0, len_q} + (LEN_W+1)'(stream_data[12:9]);
        len_sat_c = (len_sum_c > {1'b0, LEN_MAX});
`ifdef LZS_ERR_CHECK_EN
        wcount_d  = (out_valid_q && (wcount_q != CNT_W'(DEPTH))) ? wcount_q + CNT_W'(1) : wcount_q;
        bad_off_c = (offset_d == '0) || (CNT_W'(offset_d) > wcount_d);
`endif
        stream_ack   = 1'b0;
        stream_width = 4'd0;
        if (go_c) begin
            case (state_q)
                S_PROC: begin
                    stream_ack   = 1'b1;
                    stream_width = long_c ? 4'd13 : 4'd9;
                end
                S_LEN1, S_LEN2: begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd2;
                end
                S_LEN3: begin
                    stream_ack   = 1'b1;
                    stream_width = 4'd4;
                end
                default: ;
            endcase
        end
    end

    // Control FSM and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            waddr_q     <= '0;
            offset_q    <= '0;
            len_q       <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            all_end_q   <= 1'b0;
`ifdef LZS_ERR_CHECK_EN
            wcount_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            waddr_q     <= waddr_d;
`ifdef LZS_ERR_CHECK_EN
            wcount_q    <= wcount_d;
`endif
            case (state_q)
                S_IDLE: begin
                    waddr_q   <= '0;
                    all_end_q <= 1'b0;
`ifdef LZS_ERR_CHECK_EN
                    wcount_q  <= '0;
                    err_q     <= 1'b0;
`endif
                    if (ce_decode) state_q <= S_PROC;
                end
                S_PROC: if (go_c) begin
                    if (eom_c) begin
                        state_q   <= S_END;
                        all_end_q <= 1'b1;
                    end else if (lit_c) begin
                        out_data_q  <= stream_data[11:4];
                        out_valid_q <= 1'b1;
                    end else begin
                        offset_q <= offset_d;
                        state_q  <= S_LEN1;
`ifdef LZS_ERR_CHECK_EN
                        if (bad_off_c) begin
                            state_q   <= S_END;
                            all_end_q <= 1'b1;
                            err_q     <= 1'b1;
                        end
`endif
                    end
                end
                S_LEN1: if (go_c) begin
                    state_q <= S_COPY;
                    case (stream_data[12:11])
                        2'b00:   len_q <= LEN_W'(2);
                        2'b01:   len_q <= LEN_W'(3);
                        2'b10:   len_q <= LEN_W'(4);
                        default: state_q <= S_LEN2;
                    endcase
                end
                S_LEN2: if (go_c) begin
                    state_q <= S_COPY;
                    case (stream_data[12:11])
                        2'b00:   len_q <= LEN_W'(5);
                        2'b01:   len_q <= LEN_W'(6);
                        2'b10:   len_q <= LEN_W'(7);
                        default: begin
                            len_q   <= LEN_W'(8);
                            state_q <= S_LEN3;
                        end
                    endcase
                end
                S_LEN3: if (go_c) begin
                    // Nibble 4'hF means another extension nibble follows.
                    len_q <= len_sat_c ? LEN_MAX : len_sum_c[LEN_W-1:0];
                    if (stream_data[12:9] != 4'hF) state_q <= S_COPY;
`ifdef LZS_ERR_CHECK_EN
                    if (len_sat_c) begin
                        state_q   <= S_END;
                        all_end_q <= 1'b1;
                        err_q     <= 1'b1;
                    end
`endif
                end
                S_COPY: if (copy_rd_c) begin
                    out_data_q  <= rd_byte_c;
                    out_valid_q <= 1'b1;
                    len_q       <= len_q - LEN_W'(1);
                    if (len_q == LEN_W'(1)) state_q <= S_PROC;
                end
                S_END: begin
                    all_end_q <= 1'b1;
                    if (!ce_decode) begin
                        state_q   <= S_IDLE;
                        all_end_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // History window: every emitted byte lands here; contents are never reset.
    always_ff @(posedge clk) begin
        if (out_valid_q) hist_mem[waddr_q] <= out_data_q;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign all_end   = all_end_q;
`ifdef LZS_ERR_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_lzs_decode_engine.sv
// Directed self-checking bench for lzs_decode_engine; error-path vectors run when LZS_ERR_CHECK_EN is defined.
module tb_lzs_decode_engine;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce_decode;
    logic        fo_full;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        all_end;
    logic        err;

    bit          sq[$];
    logic [7:0]  got[$];
    int          gcyc[$];
    logic [7:0]  exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lzs_decode_engine #(.HIST_AW(11), .LEN_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce_decode    (ce_decode),
        .fo_full      (fo_full),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .all_end      (all_end),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bit-aligner model: next 13 queued bits, zero padded at the tail.
    task automatic refresh();
        logic [12:0] d;
        d = '0;
        for (int i = 0; i < 13; i++)
            if (i < int'(sq.size())) d[12-i] = sq[i];
        stream_data  = d;
        stream_valid = (sq.size() > 0);
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sq.push_back(v[i]);
        refresh();
    endtask

    task automatic push_lit(input logic [7:0] b);
        push_bits({23'd0, 1'b0, b}, 9);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k;
        k = 0;
        while (int'(got.size()) < n && k < 2000) begin
            tick();
            k++;
        end
        check({tag, "_timeout"}, 32'(k < 2000), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!stream_ack && k < 50);
        check({tag, "_ack_timeout"}, 32'(stream_ack), 32'd1);
    endtask

    task automatic compare_bytes(input string tag);
        repeat (4) tick();
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < int'(exp_q.size()) && i < int'(got.size()); i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
        got.delete();
        gcyc.delete();
        exp_q.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got.push_back(out_data);
            gcyc.push_back(cyc);
        end
    end

    // Consume acknowledged bits right after the edge that accepted them.
    always begin
        int take;
        @(negedge clk);
        take = (stream_ack === 1'b1 && rst === 1'b0) ? int'(stream_width) : 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < take; i++)
            if (sq.size() > 0) void'(sq.pop_front());
        refresh();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int k;
        rst       = 1'b1;
        ce_decode = 1'b0;
        fo_full   = 1'b0;
        refresh();
        repeat (3) tick();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_ack", 32'(stream_ack), 32'd0);
        check("rst_width", 32'(stream_width), 32'd0);
        check("rst_all_end", 32'(all_end), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;

        // Literal: ack width 9, byte one cycle later.
        ce_decode = 1'b1;
        push_lit(8'h41);
        @(negedge clk);
        check("idle_no_ack", 32'(stream_ack), 32'd0);
        @(negedge clk);
        check("lit_ack", 32'(stream_ack), 32'd1);
        check("lit_width", 32'(stream_width), 32'd9);
        @(negedge clk);
        check("lit_valid", 32'(out_valid), 32'd1);
        check("lit_data", 32'(out_data), 32'h41);
        tick();
        compare_bytes("lit");

        // Run-length match: offset 1, len 2.
        push_bits(32'b11_0000001_00, 11);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h41);
        wait_bytes(2, "rle");
        if (gcyc.size() >= 2) check("rle_consecutive", 32'(gcyc[1] - gcyc[0]), 32'd1);
        compare_bytes("rle");

        // 256 incrementing literals.
        for (int i = 0; i < 256; i++) push_lit(8'(i));
        wait_bytes(256, "lits");
        compare_bytes("lits");

        // Long offset 256, len 8+15+2=25, with a 5-cycle stall mid-copy.
        push_bits(32'b10_00100000000, 13);
        push_bits(32'b11_11_1111_0010, 12);
        for (int i = 0; i < 25; i++) exp_q.push_back(8'(i));
        wait_bytes(5, "bp_pre");
        fo_full = 1'b1;
        @(negedge clk);
        check("bp_inflight", 32'(out_valid), 32'd1);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("bp_stall_quiet", 32'(nv), 32'd0);
        tick();
        fo_full = 1'b0;
        wait_bytes(25, "long");
        compare_bytes("long");

        // End marker.
        push_bits(32'b110000000, 9);
        wait_ack("eom");
        check("eom_width", 32'(stream_width), 32'd9);
        @(negedge clk);
        check("eom_all_end", 32'(all_end), 32'd1);
        check("eom_no_out", 32'(out_valid), 32'd0);
        tick();
        ce_decode = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("idle_all_end", 32'(all_end), 32'd0);
        check("idle_waddr", 32'(dut.waddr_q), 32'd0);
        check("idle_err", 32'(err), 32'd0);

`ifdef LZS_ERR_CHECK_EN
        // Long-form offset 0 as the first token.
        tick();
        ce_decode = 1'b1;
        push_bits(32'b10_00000000000, 13);
        push_bits(32'b00, 2);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!all_end && k < 50);
        check("err_end_timeout", 32'(k < 50), 32'd1);
        check("err_flag", 32'(err), 32'd1);
        check("err_all_end", 32'(all_end), 32'd1);
        tick();
        ce_decode = 1'b0;
        sq.delete();
        refresh();
        repeat (3) tick();
        check("err_no_bytes", 32'(got.size()), 32'd0);
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
`endif

        // Overlapping copy: offset 2, len 7 after two literals.
        tick();
        ce_decode = 1'b1;
        push_lit(8'h01);
        push_lit(8'h02);
        push_bits(32'b11_0000010, 9);
        push_bits(32'b11_10, 4);
        for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 0) ? 8'h01 : 8'h02);
        wait_bytes(9, "ovl");
        compare_bytes("ovl");
        check("ovl_err", 32'(err), 32'd0);

        // Reset in the middle of a 13-byte run-length copy.
        push_lit(8'hAA);
        push_bits(32'b11_0000001, 9);
        push_bits(32'b11_11_0101, 8);
        wait_bytes(4, "rst_pre");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sq.delete();
        refresh();
        got.delete();
        gcyc.delete();
        exp_q.delete();
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
            tick();
        end
        check("rst_mid_quiet", 32'(nv), 32'd0);
        check("rst_mid_all_end", 32'(all_end), 32'd0);
        push_lit(8'h5A);
        wait_bytes(1, "post_rst");
        compare_bytes("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
